// File: rtl/rgb_led_pkg.sv
// Shared mode encodings and the triangle-wave helper
// for the RGB LED pattern driver.
package rgb_led_pkg;

  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_SOLID   = 2'd1;
  localparam logic [1:0] MODE_BLINK   = 2'd2;
  localparam logic [1:0] MODE_BREATHE = 2'd3;

  localparam int MAX_BITS = 16;

  // Low bits count up while the bit just above them is 0, down while it is 1.
  function automatic logic [MAX_BITS-1:0] tri_wave(
    input logic [MAX_BITS:0] ph,
    input int unsigned       bits
  );
    logic [MAX_BITS-1:0] mask;
    logic [MAX_BITS-1:0] lo;
    logic                down;
    mask = MAX_BITS'((32'd1 << bits) - 32'd1);
    lo   = ph[MAX_BITS-1:0] & mask;
    down = ((ph >> bits) & (MAX_BITS+1)'(1)) != '0;
    return down ? (~lo & mask) : lo;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One registered PWM comparator output.
// High while the shared counter is below the level.
module pwm_channel #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic [PWM_BITS-1:0] eff_level,
  output logic                out
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= 1'b0;
    end else begin
      out <= pwm_cnt < eff_level;
    end
  end

endmodule

// File: rtl/rgb_led_pattern.sv
// Multi-LED RGB pattern driver: off / solid / blink / breathe
// with PWM brightness and evenly offset phases per LED.
module rgb_led_pattern
  import rgb_led_pkg::*;
#(
  parameter int NUM_LEDS = 2,
  parameter int PWM_BITS = 8,
  parameter int STEP_DIV = 390
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          mode,
  input  logic [PWM_BITS-1:0] level_r,
  input  logic [PWM_BITS-1:0] level_g,
  input  logic [PWM_BITS-1:0] level_b,
  output logic [NUM_LEDS-1:0] led_r,
  output logic [NUM_LEDS-1:0] led_g,
  output logic [NUM_LEDS-1:0] led_b,
  output logic                period_start
);

  localparam int PH_BITS  = PWM_BITS + 1;
  localparam int DIV_BITS = $clog2(STEP_DIV);
  localparam int OFS      = (2 ** PH_BITS) / NUM_LEDS;

  localparam logic [PWM_BITS-1:0] PWM_MAX = '1;
  localparam logic [DIV_BITS-1:0] DIV_MAX =
    DIV_BITS'(STEP_DIV - 1);

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [DIV_BITS-1:0] div_cnt;
  logic [PH_BITS-1:0]  phase;
  logic [PH_BITS-1:0]  phase_lat;
  logic [1:0]          mode_lat;
  logic [PWM_BITS-1:0] lvl_r;
  logic [PWM_BITS-1:0] lvl_g;
  logic [PWM_BITS-1:0] lvl_b;
  logic                step;
  logic                wrap;

  assign step = div_cnt == DIV_MAX;
  assign wrap = pwm_cnt == PWM_MAX;

  // Pattern state is latched at the period boundary so a period
  // never changes shape part-way through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt      <= '0;
      div_cnt      <= '0;
      phase        <= '0;
      phase_lat    <= '0;
      mode_lat     <= MODE_OFF;
      lvl_r        <= '0;
      lvl_g        <= '0;
      lvl_b        <= '0;
      period_start <= 1'b0;
    end else begin
      pwm_cnt      <= pwm_cnt + 1'b1;
      div_cnt      <= step ? '0 : div_cnt + 1'b1;
      period_start <= pwm_cnt == '0;
      if (step) begin
        phase <= phase + 1'b1;
      end
      if (wrap) begin
        mode_lat  <= mode;
        lvl_r     <= level_r;
        lvl_g     <= level_g;
        lvl_b     <= level_b;
        phase_lat <= phase;
      end
    end
  end

  function automatic logic [PWM_BITS-1:0] eff_level(
    input logic [1:0]          m,
    input logic [PWM_BITS-1:0] lvl,
    input logic                down,
    input logic [PWM_BITS-1:0] tri_v
  );
    logic [2*PWM_BITS-1:0] prod;
    logic [PWM_BITS-1:0]   res;
    prod = {{PWM_BITS{1'b0}}, lvl} * {{PWM_BITS{1'b0}}, tri_v};
    res  = '0;
    case (m)
      MODE_SOLID:   res = lvl;
      MODE_BLINK:   res = down ? '0 : lvl;
      MODE_BREATHE: res = prod[2*PWM_BITS-1:PWM_BITS];
      default:      res = '0;
    endcase
    return res;
  endfunction

  for (genvar k = 0; k < NUM_LEDS; k++) begin : g_led
    localparam logic [PH_BITS-1:0] K_OFS =
      PH_BITS'(k * OFS);

    logic [PH_BITS-1:0]  ph;
    logic [PWM_BITS-1:0] tri_v;
    logic [PWM_BITS-1:0] eff_r;
    logic [PWM_BITS-1:0] eff_g;
    logic [PWM_BITS-1:0] eff_b;

    assign ph    = phase_lat + K_OFS;
    assign tri_v = PWM_BITS'(
      tri_wave((MAX_BITS+1)'(ph), PWM_BITS));

    assign eff_r = eff_level(mode_lat, lvl_r, ph[PH_BITS-1], tri_v);
    assign eff_g = eff_level(mode_lat, lvl_g, ph[PH_BITS-1], tri_v);
    assign eff_b = eff_level(mode_lat, lvl_b, ph[PH_BITS-1], tri_v);

    pwm_channel #(.PWM_BITS(PWM_BITS)) u_r (
      .clk       (clk),
      .rst_n     (rst_n),
      .pwm_cnt   (pwm_cnt),
      .eff_level (eff_r),
      .out       (led_r[k])
    );

    pwm_channel #(.PWM_BITS(PWM_BITS)) u_g (
      .clk       (clk),
      .rst_n     (rst_n),
      .pwm_cnt   (pwm_cnt),
      .eff_level (eff_g),
      .out       (led_g[k])
    );

    pwm_channel #(.PWM_BITS(PWM_BITS)) u_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .pwm_cnt   (pwm_cnt),
      .eff_level (eff_b),
      .out       (led_b[k])
    );
  end

endmodule
